spi_bus_port: RTL and testbench
===============================

// Module: spi_bus_port
// PURPOSE
//  68000-bus responder exposing a byte-wide SPI master at a fixed Z2 I/O window; the slave end of CPU cycles issued on AS_CPU_n.
//  Drives SPI_CS_n/SCK/MOSI for the on-card flash/SD. Asserts DTACK_n and ACCESS (for OVR_n gating) on decoded cycles.
// PARAMETERS
//  BASE_ADDR    8'hE9  A[23:16] match value for the register window
//  WAIT_STATES  1      extra C7M cycles between decode and DTACK_n assertion (0..7)
// PORTS
//  C7M        in   1   system clock; all state on its rising edge
//  RESET_n    in   1   asynchronous active-low reset
//  A_HIGH     in   8   A[23:16]
//  A_LOW      in   2   A[2:1], register select
//  AS_CPU_n   in   1   CPU address strobe
//  UDS_n      in   1   upper data strobe
//  LDS_n      in   1   lower data strobe
//  RW_n       in   1   1=read, 0=write
//  D_IN       in   16  CPU data bus (write data)
//  D_OUT      out  16  read data
//  D_OE       out  1   drive D_OUT onto D
//  DTACK_n    out  1   data acknowledge to CPU, AND-ed at top level
//  ACCESS     out  1   high while a cycle to this window is in progress
//  SPI_CS_n   out  1   SPI chip select
//  SPI_SCK    out  1   SPI clock, mode 0
//  SPI_MOSI   out  1   SPI data out
//  SPI_MISO   in   1   SPI data in
//  IRQ_n      out  1   transfer-done interrupt (only with SPI_IRQ_EN)
// BEHAVIOUR
//  Reset: D_OUT=0, D_OE=0, DTACK_n=1, ACCESS=0, SPI_CS_n=1, SCK=0, MOSI=0, IRQ_n=1, RX=0, DIV=4'hF, BUSY=0.
//  AS_CPU_n, UDS_n and LDS_n pass through 2-flop synchronisers; match = !as_s && A_HIGH==BASE_ADDR.
//  Bus FSM: B_IDLE -(match)-> B_WAIT -(cnt==WAIT_STATES, and !BUSY if write)-> B_ACK -> B_HOLD -(as_s high)-> B_IDLE.
//  ACCESS=1 in B_WAIT/B_ACK/B_HOLD. DTACK_n = !((B_ACK|B_HOLD) && !AS_CPU_n), using raw AS so release is immediate.
//  Reads: D_OE=RW_n in B_ACK/B_HOLD while AS_CPU_n low; data latched on entry to B_ACK. Reads never stall.
//  Writes: latched on B_WAIT->B_ACK when the synced strobe is low. Any write while BUSY holds B_WAIT until BUSY clears.
//  Registers (A_LOW):
//   00 DATA: LDS write loads TX and starts a transfer. Read = {8'h00,RX}. UDS-only write is ignored.
//   01 CTRL: W[0]=CS (1 drives SPI_CS_n low), W[4:1]=DIV, W[5]=IRQ_EN. R={BUSY,IRQ_PEND,8'h0,IRQ_EN,DIV,CS}.
//   10/11: read 16'h0000, writes ignored, still acknowledged.
//  SPI: mode 0, MSB first. Half-period = DIV+1 C7M cycles. MOSI valid one half-period before the first rising edge.
//   MISO sampled on the rising edge; MOSI shifts on the falling edge. 8 bits per transfer.
//   BUSY set the cycle after the DATA write. RX updated and BUSY cleared on the cycle after the 8th falling edge.
//   SCK idles low. SPI_CS_n is never toggled by the shifter.
//  Reset mid-transfer aborts immediately to reset values. AS rising mid-B_WAIT returns to B_IDLE with no write performed.
// CONFIGURATION
//  SPI_IRQ_EN defined: IRQ_PEND sets on transfer done if IRQ_EN=1; IRQ_n=!IRQ_PEND; a CTRL read clears IRQ_PEND.
//   If set and clear coincide, set wins.
//  SPI_IRQ_EN undefined: IRQ_n tied 1; CTRL bits 5 and 14 read 0; writes to bit 5 are ignored.
// STRUCTURE
//  spi_defs.vh: register offsets, CTRL bit positions, bus FSM and shifter state encodings.
//  Sub-module spi_shifter: divider, bit counter, shift register; start/tx[7:0] in, busy/rx[7:0]/done out.
// TESTING
//  Read CTRL after reset -> 16'h001E, DTACK_n low WAIT_STATES+~3 C7M after AS, D_OE high, release on AS high.
//  Write CTRL=16'h0001 then DATA=16'h00A5 with MISO looped to MOSI, DIV=0 -> CS low, 8 SCK periods of 2 C7M,
//   MOSI=10100101, RX=8'hA5, BUSY high then low.
//  Second DATA write issued while BUSY -> DTACK_n held high until BUSY falls; second byte sent intact.
//  Access with A_HIGH=8'hE8 -> DTACK_n, ACCESS and D_OE stay inactive.
//  Assert RESET_n low at bit 4 of a transfer -> SCK=0, CS_n=1, BUSY=0 at once; RX=0 after release.
//  With SPI_IRQ_EN and IRQ_EN=1: transfer -> IRQ_n low; CTRL read -> bit14=1, IRQ_n high next cycle.

Source files
------------

// File: rtl/spi_bus_port_pkg.sv
// Shared definitions for spi_bus_port: register offsets, CTRL bit positions,
// bus and shifter state encodings, and the CTRL read-word builder.
package spi_bus_port_pkg;

   localparam logic [1:0] REG_DATA = 2'b00;
   localparam logic [1:0] REG_CTRL = 2'b01;

   localparam int CTRL_CS       = 0;
   localparam int CTRL_DIV_LSB  = 1;
   localparam int CTRL_IRQ_EN   = 5;
   localparam int CTRL_IRQ_PEND = 14;
   localparam int CTRL_BUSY     = 15;

   typedef enum logic [1:0] {B_IDLE, B_WAIT, B_ACK, B_HOLD} bus_state_t;
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} spi_state_t;

   function automatic logic [15:0] ctrl_word(input logic busy, input logic pend,
                                             input logic irq_en, input logic [3:0] div,
                                             input logic cs);
      logic [15:0] w;
      w = '0;
      w[CTRL_BUSY]            = busy;
      w[CTRL_IRQ_PEND]        = pend;
      w[CTRL_IRQ_EN]          = irq_en;
      w[CTRL_DIV_LSB +: 4]    = div;
      w[CTRL_CS]              = cs;
      return w;
   endfunction

endpackage

// File: rtl/spi_bus_port_shifter.sv
// Mode-0 SPI byte shifter: programmable half-period divider, MSB-first,
// MISO sampled on SCK rise, MOSI advanced on SCK fall.
module spi_bus_port_shifter
   import spi_bus_port_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_start,
   input  logic [7:0] i_tx,
   input  logic [3:0] i_div,
   input  logic       i_miso,
   output logic       o_busy,
   output logic       o_done,
   output logic [7:0] o_rx,
   output logic       o_sck,
   output logic       o_mosi,
   output spi_state_t o_state
);

   // Handshake: i_start is taken only while o_busy is low; o_busy rises on
   // the same edge that accepts it and falls with o_done, when o_rx is valid.
   spi_state_t r_state;
   spi_state_t w_next;
   logic [3:0] r_div_cnt;
   logic [2:0] r_bit_cnt;
   logic [7:0] r_tx_sh;
   logic [7:0] r_rx_sh;
   logic [7:0] r_rx;
   logic       r_sck;
   logic       w_tick;
   logic       w_last_fall;

   assign w_tick      = (r_div_cnt == i_div);
   assign w_last_fall = (r_state == S_RUN) && w_tick && r_sck && (r_bit_cnt == 3'd7);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (i_start) w_next = S_RUN;
         S_RUN:   if (w_last_fall) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_div_cnt <= '0;
         r_bit_cnt <= '0;
         r_tx_sh   <= '0;
         r_rx_sh   <= '0;
         r_rx      <= '0;
         r_sck     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_tx_sh   <= i_tx;
                  r_div_cnt <= '0;
                  r_bit_cnt <= '0;
                  r_sck     <= 1'b0;
               end
            end
            S_RUN: begin
               if (w_tick) begin
                  r_div_cnt <= '0;
                  r_sck     <= !r_sck;
                  if (!r_sck) begin
                     r_rx_sh <= {r_rx_sh[6:0], i_miso};
                  end else begin
                     r_tx_sh   <= {r_tx_sh[6:0], 1'b0};
                     r_bit_cnt <= r_bit_cnt + 3'd1;
                  end
               end else begin
                  r_div_cnt <= r_div_cnt + 4'd1;
               end
            end
            S_DONE:  r_rx <= r_rx_sh;
            default: ;
         endcase
      end
   end

   assign o_busy  = (r_state != S_IDLE);
   assign o_done  = (r_state == S_DONE);
   assign o_rx    = r_rx;
   assign o_sck   = r_sck;
   assign o_mosi  = r_tx_sh[7];
   assign o_state = r_state;

endmodule

// File: rtl/spi_bus_port.sv
// 68000 bus responder for a byte-wide SPI master in a Z2 I/O window.
// Optional transfer-done interrupt is built when SPI_IRQ_EN is defined.
module spi_bus_port
   import spi_bus_port_pkg::*;
#(
   parameter logic [7:0] BASE_ADDR   = 8'hE9,
   parameter int         WAIT_STATES = 1
)(
   input  logic        C7M,
   input  logic        RESET_n,
   input  logic [7:0]  A_HIGH,
   input  logic [1:0]  A_LOW,
   input  logic        AS_CPU_n,
   input  logic        UDS_n,
   input  logic        LDS_n,
   input  logic        RW_n,
   input  logic [15:0] D_IN,
   output logic [15:0] D_OUT,
   output logic        D_OE,
   output logic        DTACK_n,
   output logic        ACCESS,
   output logic        SPI_CS_n,
   output logic        SPI_SCK,
   output logic        SPI_MOSI,
   input  logic        SPI_MISO,
   output logic        IRQ_n,
   output logic [3:0]  o_dbg_state
);

   bus_state_t  r_bus_state;
   bus_state_t  w_bus_next;
   spi_state_t  w_spi_state;
   logic        r_as_m, r_as_s, r_uds_m, r_uds_s, r_lds_m, r_lds_s;
   logic [2:0]  r_cnt;
   logic        r_cs;
   logic [3:0]  r_div;
   logic [15:0] r_dout;
   logic        w_match, w_write, w_strobe, w_wait_done, w_go, w_latch, w_acked;
   logic        w_wr_data, w_wr_ctrl, w_rd_ctrl;
   logic        w_busy, w_done;
   logic [7:0]  w_rx;
   logic        w_irq_en, w_irq_pend;
   logic        w_unused_bits;

   always_ff @(posedge C7M or negedge RESET_n) begin
      if (!RESET_n) begin
         {r_as_m, r_as_s, r_uds_m, r_uds_s, r_lds_m, r_lds_s} <= 6'b111111;
      end else begin
         r_as_m  <= AS_CPU_n;  r_as_s  <= r_as_m;
         r_uds_m <= UDS_n;     r_uds_s <= r_uds_m;
         r_lds_m <= LDS_n;     r_lds_s <= r_lds_m;
      end
   end

   assign w_match     = !r_as_s && (A_HIGH == BASE_ADDR);
   assign w_write     = !RW_n;
   assign w_strobe    = !r_uds_s || !r_lds_s;
   assign w_wait_done = (r_cnt == 3'(WAIT_STATES));
   // A write is only acknowledged once a data strobe has arrived and the shifter is free.
   assign w_go        = w_wait_done && (!w_write || (w_strobe && !w_busy));
   assign w_acked     = (r_bus_state == B_ACK) || (r_bus_state == B_HOLD);

   always_ff @(posedge C7M or negedge RESET_n) begin
      if (!RESET_n) r_bus_state <= B_IDLE;
      else          r_bus_state <= w_bus_next;
   end

   always_comb begin
      w_bus_next = r_bus_state;
      w_latch    = 1'b0;
      case (r_bus_state)
         B_IDLE: if (w_match) w_bus_next = B_WAIT;
         B_WAIT: begin
            if (r_as_s) begin
               w_bus_next = B_IDLE;
            end else if (w_go) begin
               w_bus_next = B_ACK;
               w_latch    = 1'b1;
            end
         end
         B_ACK:   w_bus_next = B_HOLD;
         B_HOLD:  if (r_as_s) w_bus_next = B_IDLE;
         default: w_bus_next = B_IDLE;
      endcase
   end

   always_ff @(posedge C7M or negedge RESET_n) begin
      if (!RESET_n)                                    r_cnt <= '0;
      else if (r_bus_state != B_WAIT)                  r_cnt <= '0;
      else if (!w_wait_done)                           r_cnt <= r_cnt + 3'd1;
   end

   assign w_wr_data = w_latch && w_write && !r_lds_s && (A_LOW == REG_DATA);
   assign w_wr_ctrl = w_latch && w_write && !r_lds_s && (A_LOW == REG_CTRL);
   assign w_rd_ctrl = w_latch && !w_write && (A_LOW == REG_CTRL);

   always_ff @(posedge C7M or negedge RESET_n) begin
      if (!RESET_n) begin
         r_cs   <= 1'b0;
         r_div  <= 4'hF;
         r_dout <= '0;
      end else begin
         if (w_wr_ctrl) begin
            r_cs  <= D_IN[CTRL_CS];
            r_div <= D_IN[CTRL_DIV_LSB +: 4];
         end
         if (w_latch && !w_write) begin
            case (A_LOW)
               REG_DATA: r_dout <= {8'h00, w_rx};
               REG_CTRL: r_dout <= ctrl_word(w_busy, w_irq_pend, w_irq_en, r_div, r_cs);
               default:  r_dout <= 16'h0000;
            endcase
         end
      end
   end

`ifdef SPI_IRQ_EN
   logic r_irq_en, r_irq_pend;

   always_ff @(posedge C7M or negedge RESET_n) begin
      if (!RESET_n) begin
         r_irq_en   <= 1'b0;
         r_irq_pend <= 1'b0;
      end else begin
         if (w_wr_ctrl) r_irq_en <= D_IN[CTRL_IRQ_EN];
         // Completion outranks a coincident CTRL read so no interrupt is lost.
         if (w_done && r_irq_en) r_irq_pend <= 1'b1;
         else if (w_rd_ctrl)     r_irq_pend <= 1'b0;
      end
   end

   assign w_irq_en      = r_irq_en;
   assign w_irq_pend    = r_irq_pend;
   assign IRQ_n         = !r_irq_pend;
   assign w_unused_bits = &{1'b0, D_IN[15:8], D_IN[7:6]};
`else
   assign w_irq_en      = 1'b0;
   assign w_irq_pend    = 1'b0;
   assign IRQ_n         = 1'b1;
   assign w_unused_bits = &{1'b0, D_IN[15:8], D_IN[7:5], w_done, w_rd_ctrl};
`endif

   spi_bus_port_shifter u_shifter (
      .i_clk   (C7M),
      .i_rst_n (RESET_n),
      .i_start (w_wr_data),
      .i_tx    (D_IN[7:0]),
      .i_div   (r_div),
      .i_miso  (SPI_MISO),
      .o_busy  (w_busy),
      .o_done  (w_done),
      .o_rx    (w_rx),
      .o_sck   (SPI_SCK),
      .o_mosi  (SPI_MOSI),
      .o_state (w_spi_state)
   );

   // Raw AS gates DTACK/D_OE so the CPU sees release without synchroniser lag.
   assign DTACK_n     = !(w_acked && !AS_CPU_n);
   assign D_OE        = RW_n && w_acked && !AS_CPU_n;
   assign D_OUT       = r_dout;
   assign ACCESS      = (r_bus_state != B_IDLE);
   assign SPI_CS_n    = !r_cs;
   assign o_dbg_state = {w_spi_state, r_bus_state};

endmodule

// File: tb/tb_spi_bus_port.sv
// Directed bench for spi_bus_port: bus cycles driven on C7M falling edges,
// outputs checked after rising edges against a register/transfer model.
module tb_spi_bus_port;
   import spi_bus_port_pkg::*;

   localparam int WS = 1;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  a_high = 8'h00;
   logic [1:0]  a_low = 2'b00;
   logic        as_n = 1'b1, uds_n = 1'b1, lds_n = 1'b1, rw_n = 1'b1;
   logic [15:0] d_in = 16'h0000;
   logic [15:0] d_out;
   logic        d_oe, dtack_n, access, cs_n, sck, mosi, miso, irq_n;
   logic [3:0]  dbg;

   int total = 0;
   int bad   = 0;

   // behavioural model
   logic       m_cs  = 1'b0;
   int         m_div = 15;
   logic [7:0] m_rx  = 8'h00;
   logic [7:0] exp_q[$];
   int         done_cnt = 0;
   int         last_ack_done = 0;

   // SPI monitor state
   logic       prev_sck = 1'b0;
   int         bit_n = 0;
   int         phase_len = 0;
   logic [7:0] cur = 8'h00;

   assign miso = mosi;

   always #5 clk = ~clk;

   spi_bus_port #(.BASE_ADDR(8'hE9), .WAIT_STATES(WS)) dut (
      .C7M(clk), .RESET_n(rst_n), .A_HIGH(a_high), .A_LOW(a_low),
      .AS_CPU_n(as_n), .UDS_n(uds_n), .LDS_n(lds_n), .RW_n(rw_n),
      .D_IN(d_in), .D_OUT(d_out), .D_OE(d_oe), .DTACK_n(dtack_n),
      .ACCESS(access), .SPI_CS_n(cs_n), .SPI_SCK(sck), .SPI_MOSI(mosi),
      .SPI_MISO(miso), .IRQ_n(irq_n), .o_dbg_state(dbg)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // compare process: every cycle out of reset
   always @(posedge clk) begin
      #2;
      if (!rst_n) begin
         prev_sck  = 1'b0;
         bit_n     = 0;
         phase_len = 0;
         cur       = 8'h00;
      end else begin
         check("cs_n", cs_n, !m_cs);
         if (as_n) begin
            check("dtack_idle", dtack_n, 1'b1);
            check("d_oe_idle", d_oe, 1'b0);
         end
`ifndef SPI_IRQ_EN
         check("irq_n_tied", irq_n, 1'b1);
`endif
         if (sck !== prev_sck) begin
            if (sck) begin
               if (bit_n > 0) check("sck_low_len", phase_len, m_div + 1);
               cur = {cur[6:0], mosi};
               bit_n++;
               if (bit_n == 8) begin
                  if (exp_q.size() == 0) begin
                     check("spurious_byte", 0, 1);
                  end else begin
                     logic [7:0] e;
                     e = exp_q.pop_front();
                     check("mosi_byte", cur, e);
                     m_rx = e;
                  end
                  done_cnt++;
                  bit_n = 0;
               end
            end else begin
               check("sck_high_len", phase_len, m_div + 1);
            end
            phase_len = 1;
         end else begin
            phase_len++;
         end
         prev_sck = sck;
      end
   end

   task automatic bus_cycle(input logic [7:0] ah, input logic [1:0] al, input logic rw,
                            input logic u, input logic l, input logic [15:0] wd,
                            output logic [15:0] rd, output int lat);
      logic got;
      got = 1'b0;
      lat = 0;
      rd  = 16'h0;
      @(negedge clk);
      a_high = ah; a_low = al; rw_n = rw; d_in = wd;
      as_n = 1'b0; uds_n = u; lds_n = l;
      while (!got && lat < 1000) begin
         @(posedge clk); #1;
         lat++;
         if (!dtack_n) begin
            got = 1'b1;
            last_ack_done = done_cnt;
            if (!rw && !l && al == REG_CTRL) begin
               m_cs  = wd[0];
               m_div = int'(wd[4:1]);
            end
            if (!rw && !l && al == REG_DATA) exp_q.push_back(wd[7:0]);
         end
      end
      check("dtack_seen", got, 1'b1);
      rd = d_out;
      check("d_oe_dir", d_oe, rw);
      check("access_busy", access, 1'b1);
      @(negedge clk);
      as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; rw_n = 1'b1;
      #1 check("dtack_release", dtack_n, 1'b1);
      repeat (4) @(posedge clk);
   endtask

   task automatic rd_chk(input logic [1:0] al, input logic [15:0] exp, input string nm);
      logic [15:0] rd;
      int lat;
      bus_cycle(8'hE9, al, 1'b1, 1'b0, 1'b0, 16'h0, rd, lat);
      check(nm, rd, exp);
   endtask

   task automatic wr(input logic [1:0] al, input logic [15:0] wd);
      logic [15:0] rd;
      int lat;
      bus_cycle(8'hE9, al, 1'b0, 1'b0, 1'b0, wd, rd, lat);
   endtask

   task automatic wait_done(input int target);
      int n;
      n = 0;
      while (done_cnt < target && n < 2000) begin
         @(posedge clk); n++;
      end
      check("xfer_done", done_cnt >= target, 1'b1);
      repeat (3) @(posedge clk);
   endtask

   initial begin
      logic [15:0] rd;
      int lat;
      int n;

      repeat (3) @(posedge clk);
      #1;
      check("rst_d_out", d_out, 16'h0000);
      check("rst_d_oe", d_oe, 1'b0);
      check("rst_dtack", dtack_n, 1'b1);
      check("rst_access", access, 1'b0);
      check("rst_cs_n", cs_n, 1'b1);
      check("rst_sck", sck, 1'b0);
      check("rst_mosi", mosi, 1'b0);
      check("rst_irq_n", irq_n, 1'b1);
      @(negedge clk); rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // reset-state reads
      bus_cycle(8'hE9, REG_CTRL, 1'b1, 1'b0, 1'b0, 16'h0, rd, lat);
      check("ctrl_reset", rd, 16'h001E);
      check("dtack_latency", (lat >= WS + 2) && (lat <= WS + 5), 1'b1);
      rd_chk(REG_DATA, 16'h0000, "data_reset");

      // foreign address: nothing responds
      @(negedge clk);
      a_high = 8'hE8; a_low = REG_CTRL; rw_n = 1'b1; as_n = 1'b0; uds_n = 1'b0; lds_n = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         check("miss_dtack", dtack_n, 1'b1);
         check("miss_access", access, 1'b0);
         check("miss_d_oe", d_oe, 1'b0);
      end
      @(negedge clk); as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
      repeat (4) @(posedge clk);

      // CS on, DIV=0, loopback byte A5
      wr(REG_CTRL, 16'h0001);
      rd_chk(REG_CTRL, 16'h0001, "ctrl_cs_div0");
      wr(REG_DATA, 16'h00A5);
      wait_done(1);
      rd_chk(REG_DATA, {8'h00, m_rx}, "rx_model_a5");
      rd_chk(REG_DATA, 16'h00A5, "rx_lit_a5");
      rd_chk(REG_CTRL, 16'h0001, "ctrl_idle_after");

      // upper-byte-only DATA write must not start a transfer
      bus_cycle(8'hE9, REG_DATA, 1'b0, 1'b0, 1'b1, 16'hFF00, rd, lat);
      repeat (40) @(posedge clk);
      check("uds_only_no_xfer", done_cnt, 1);
      check("uds_only_no_bits", bit_n, 0);

      // unused offsets: acknowledged, read zero
      wr(2'b10, 16'h1234);
      rd_chk(2'b10, 16'h0000, "reg2_zero");
      rd_chk(2'b11, 16'h0000, "reg3_zero");

      // DIV=3; second write stalls until the first byte completes
      wr(REG_CTRL, 16'h0007);
      wr(REG_DATA, 16'h003C);
      rd_chk(REG_CTRL, 16'h8007, "ctrl_busy");
      wr(REG_DATA, 16'h00C3);
      check("stall_until_done", last_ack_done, 2);
      wait_done(3);
      rd_chk(REG_DATA, 16'h00C3, "rx_c3");

      // AS withdrawn during the wait phase: no write lands
      @(negedge clk);
      a_high = 8'hE9; a_low = REG_CTRL; rw_n = 1'b0; d_in = 16'h0001;
      as_n = 1'b0; uds_n = 1'b0; lds_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk); as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; rw_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         check("abort_no_dtack", dtack_n, 1'b1);
      end
      rd_chk(REG_CTRL, 16'h0007, "abort_ctrl_kept");

      // reset in the middle of a byte
      wr(REG_DATA, 16'h005A);
      n = 0;
      while (bit_n != 4 && n < 500) begin
         @(posedge clk); #3; n++;
      end
      check("reached_bit4", bit_n, 4);
      rst_n = 1'b0;
      m_cs = 1'b0; m_div = 15; m_rx = 8'h00;
      exp_q.delete();
      #1;
      check("midrst_sck", sck, 1'b0);
      check("midrst_cs_n", cs_n, 1'b1);
      check("midrst_spi_idle", dbg[3:2], S_IDLE);
      check("midrst_dtack", dtack_n, 1'b1);
      repeat (3) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      repeat (2) @(posedge clk);
      rd_chk(REG_CTRL, 16'h001E, "ctrl_after_rst");
      rd_chk(REG_DATA, 16'h0000, "rx_after_rst");

`ifdef SPI_IRQ_EN
      n = done_cnt;
      wr(REG_CTRL, 16'h0021);
      wr(REG_DATA, 16'h0081);
      wait_done(n + 1);
      check("irq_asserted", irq_n, 1'b0);
      rd_chk(REG_CTRL, 16'h4021, "ctrl_irq_pend");
      check("irq_cleared", irq_n, 1'b1);
      rd_chk(REG_DATA, 16'h0081, "rx_81");
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
